// File: rtl/mem_port_arbiter.sv
// Arbitrates one external memory port between instruction fetch and load/store.
// Data has priority, bounded by a streak limit so fetch always makes progress.
module mem_port_arbiter #(
    parameter int unsigned ADDR_W       = 32,
    parameter int unsigned DATA_W       = 32,
    parameter int unsigned WAIT_CYCLES  = 2,
    parameter int unsigned MAX_D_STREAK = 3
) (
    input  logic              CLK,
    input  logic              reset,
    input  logic              f_req,
    input  logic [ADDR_W-1:0] f_addr,
    output logic [DATA_W-1:0] f_rdata,
    output logic              f_ack,
    input  logic              d_req,
    input  logic              d_we,
    input  logic [ADDR_W-1:0] d_addr,
    input  logic [DATA_W-1:0] d_wdata,
    output logic [DATA_W-1:0] d_rdata,
    output logic              d_ack,
    output logic              m_cs,
    output logic              m_we,
    output logic [ADDR_W-1:0] m_addr,
    output logic [DATA_W-1:0] m_wdata,
    input  logic [DATA_W-1:0] m_rdata,
    output logic              busy,
    output logic              owner
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        ACK    = 2'd2
    } state_t;

    localparam logic [3:0] WAIT_INIT  = 4'(WAIT_CYCLES);
    localparam logic [3:0] STREAK_MAX = 4'(MAX_D_STREAK);

    state_t            state;
    state_t            state_nxt;
    logic [3:0]        wait_cnt;
    logic [3:0]        streak;
    logic [ADDR_W-1:0] lat_addr;
    logic [DATA_W-1:0] lat_wdata;
    logic              lat_we;
    logic              grant_d;
    logic              start;

    // NOTE: every always_comb output gets a default first so no path can infer a latch.
    always_comb begin
        state_nxt = state;
        grant_d   = d_req && !(f_req && (streak == STREAK_MAX));
        start     = 1'b0;
        case (state)
            IDLE: begin
                if (f_req || d_req) begin
                    start     = 1'b1;
                    state_nxt = ACCESS;
                end
            end
            ACCESS: begin
                if (wait_cnt == 4'd0) begin
                    state_nxt = ACK;
                end
            end
            ACK:     state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments only, so every register
    // sees pre-edge values of the others.
    always_ff @(posedge CLK or negedge reset) begin
        if (!reset) begin
            state     <= IDLE;
            wait_cnt  <= 4'd0;
            streak    <= 4'd0;
            lat_addr  <= '0;
            lat_wdata <= '0;
            lat_we    <= 1'b0;
            owner     <= 1'b0;
            f_rdata   <= '0;
            d_rdata   <= '0;
        end else begin
            state <= state_nxt;
            if (start) begin
                owner    <= grant_d;
                wait_cnt <= WAIT_INIT;
                lat_addr <= grant_d ? d_addr : f_addr;
                lat_we   <= grant_d && d_we;
                if (grant_d) begin
                    lat_wdata <= d_wdata;
                end
                // Streak counts only data grants that made a waiting fetch wait longer.
                if (grant_d && f_req) begin
                    if (streak != STREAK_MAX) begin
                        streak <= streak + 4'd1;
                    end
                end else begin
                    streak <= 4'd0;
                end
            end
            if (state == ACCESS) begin
                if (wait_cnt != 4'd0) begin
                    wait_cnt <= wait_cnt - 4'd1;
                end else if (!owner) begin
                    f_rdata <= m_rdata;
                end else if (!lat_we) begin
                    d_rdata <= m_rdata;
                end
            end
        end
    end

    assign m_cs    = (state == ACCESS);
    assign m_we    = m_cs && lat_we;
    assign m_addr  = lat_addr;
    assign m_wdata = lat_wdata;
    assign f_ack   = (state == ACK) && !owner;
    assign d_ack   = (state == ACK) && owner;
    assign busy    = (state != IDLE);

endmodule

// File: doc/mem_port_arbiter.md
Name: mem_port_arbiter

Overview:
- Shares the single external memory port between the CPU's instruction-fetch requester and its load/store requester.
- Each grant runs as a multicycle access with a programmable number of wait states.
- Sits between the cpu core and the memory bus (CS/WE/ADDR/data), replacing separate program and data ports with one arbitrated port.
- Data accesses have priority, with a fairness limit so that fetch is never starved.

Parameters:
- ADDR_W, 32, address width.
- DATA_W, 32, data width.
- WAIT_CYCLES, 2, extra memory cycles per access (legal range 0..15).
- MAX_D_STREAK, 3, maximum consecutive data grants while a fetch is pending (legal range 1..15).

Ports:
- CLK  in  1  system clock; all logic on the rising edge.
- reset  in  1  asynchronous, active-low reset (0 = reset).
- f_req  in  1  fetch request; held high until f_ack.
- f_addr  in  ADDR_W  fetch address.
- f_rdata  out  DATA_W  fetched word; registered.
- f_ack  out  1  one-cycle fetch completion pulse.
- d_req  in  1  data request; held high until d_ack.
- d_we  in  1  1 = store, 0 = load.
- d_addr  in  ADDR_W  data address.
- d_wdata  in  DATA_W  store data.
- d_rdata  out  DATA_W  load result; registered.
- d_ack  out  1  one-cycle data completion pulse.
- m_cs  out  1  memory chip select.
- m_we  out  1  memory write enable.
- m_addr  out  ADDR_W  memory address.
- m_wdata  out  DATA_W  memory write data.
- m_rdata  in  DATA_W  memory read data; valid while m_cs is high.
- busy  out  1  1 whenever state is not IDLE.
- owner  out  1  owner of the current or last grant: 1 = data, 0 = fetch.

Behaviour:
- Reset (reset=0, asynchronous):
  - State goes to IDLE.
  - All outputs are 0: m_cs, m_we, m_addr, m_wdata, f_rdata, d_rdata, f_ack, d_ack, busy, owner.
  - Wait counter and streak counter are 0.
  - A transaction in flight is dropped with no ack.
- States:
  - IDLE
  - ACCESS
  - ACK
- IDLE:
  - Stays in IDLE when f_req=0 and d_req=0.
  - Otherwise picks a winner, latches the winner's address, plus d_we and d_wdata for data, sets the wait counter to WAIT_CYCLES, and goes to ACCESS.
- Arbitration, evaluated only in IDLE:
  - Only d_req: data wins.
  - Only f_req: fetch wins.
  - Both: data wins unless streak == MAX_D_STREAK, in which case fetch wins.
- Streak counter:
  - Increments on a data grant made while f_req=1.
  - Clears on any fetch grant.
  - Clears on a data grant made while f_req=0.
  - Saturates at MAX_D_STREAK.
- ACCESS:
  - m_cs=1; m_addr and m_wdata come from the latched values.
  - m_we = latched we for a data grant, 0 for a fetch grant.
  - The counter decrements each cycle while it is nonzero.
  - In the cycle the counter is 0: m_rdata is captured into f_rdata or d_rdata (loads and fetches only; stores leave d_rdata unchanged), and the next state is ACK.
  - m_cs is high for exactly WAIT_CYCLES+1 cycles.
- ACK:
  - m_cs=0 and m_we=0.
  - The owner's ack is 1 for exactly this one cycle.
  - Next state is IDLE unconditionally; requests are ignored during ACK, so a request still held is not serviced twice.
- Latency:
  - A request sampled at IDLE edge k gives m_cs high on cycles k+1 .. k+1+WAIT_CYCLES.
  - The ack is high on cycle k+2+WAIT_CYCLES.
  - Minimum spacing between grant starts is WAIT_CYCLES+3 cycles.
- Outputs and boundaries:
  - f_ack and d_ack are never high together.
  - busy = (state != IDLE).
  - m_addr and m_wdata hold their last values in IDLE and ACK.
  - Request inputs are not required to stay stable after the grant; only the values latched in IDLE are used.
  - WAIT_CYCLES=0: a single ACCESS cycle.
  - Dropping a req mid-access does not abort the access; the ack still pulses.

Test Plan:
- Reset: hold reset=0 with both reqs high, then release → no m_cs for 1 cycle; grant goes to data, owner=1, all other outputs 0 until the grant.
- Fetch only: WAIT_CYCLES=2, f_req=1, f_addr=0x40, m_rdata=0x064f → m_cs high 3 cycles with m_addr=0x40 and m_we=0; f_ack pulses on the 4th cycle after the grant edge; f_rdata=0x064f.
- Store: d_req=1, d_we=1, d_addr=0x100, d_wdata=0x22b4 → m_we=1 and m_wdata=0x22b4 for 3 cycles; d_ack pulse; d_rdata unchanged.
- Contention/fairness: both reqs held high continuously, MAX_D_STREAK=3 → grant order D,D,D,F,D,D,D,F; f_ack and d_ack never coincide.
- Reset mid-access: drive reset=0 during the 2nd ACCESS cycle → m_cs drops immediately; no ack; IDLE after release.
- WAIT_CYCLES=0: back-to-back fetches → m_cs high 1 cycle; ack 1 cycle later; grants every 3 cycles.
